// File: rtl/warmboot_sequencer.sv
// Warmboot sequencer for the iCE40 SB_WARMBOOT primitive.
// Accepts an explicit boot request or a no-host timeout, waits for the SPI
// flash bus to be quiet, then drives S1/S0 ahead of BOOT so the device never
// reconfigures during a flash transaction.
module warmboot_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 96000000,
    parameter int unsigned IDLE_CYCLES    = 48,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter logic [1:0]  DEFAULT_IMAGE  = 2'b01,
    parameter int unsigned CNT_W          = 27
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       usb_active,
    input  logic       timeout_en,
    input  logic       spi_cs_n,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SETUP = 2'd2;
    localparam logic [1:0] ST_FIRE  = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD    = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [1:0]       state_q,     state_d;
    logic             host_seen_q, host_seen_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       img_q,       img_d;
    logic [1:0]       sel_q,       sel_d;
    logic             boot_q,      boot_d;
    logic             busy_q,      busy_d;

    logic cnt_zero;
    logic host_now;
    logic timer_run;

    assign cnt_zero  = (cnt_q == '0);
    // Host activity in the current cycle already counts, so a usb_active
    // pulse coinciding with expiry wins over the timeout.
    assign host_now  = host_seen_q | usb_active;
    assign timer_run = timeout_en & ~host_now;

    // Next-state logic: one shared down-counter serves timeout, drain and setup.
    always_comb begin
        state_d     = state_q;
        host_seen_d = host_seen_q;
        cnt_d       = cnt_q;
        img_d       = img_q;
        sel_d       = sel_q;
        boot_d      = boot_q;
        busy_d      = busy_q;
        case (state_q)
            ST_WAIT: begin
                host_seen_d = host_now;
                if (timer_run && !cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                // An explicit request beats a coincident timeout expiry.
                if (boot_req) begin
                    img_d   = boot_image;
                    state_d = ST_DRAIN;
                    cnt_d   = IDLE_LOAD;
                    busy_d  = 1'b1;
                end else if (timer_run && cnt_zero) begin
                    img_d   = DEFAULT_IMAGE;
                    state_d = ST_DRAIN;
                    cnt_d   = IDLE_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Any flash activity restarts the quiet window.
                if (!spi_cs_n) begin
                    cnt_d = IDLE_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    sel_d   = img_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_FIRE;
                    boot_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FIRE: begin
                // Terminal: everything holds until reset or reconfiguration.
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State and output registers; reset restores the idle image immediately.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT;
            host_seen_q <= 1'b0;
            cnt_q       <= TIMEOUT_LOAD;
            img_q       <= DEFAULT_IMAGE;
            sel_q       <= DEFAULT_IMAGE;
            boot_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            host_seen_q <= host_seen_d;
            cnt_q       <= cnt_d;
            img_q       <= img_d;
            sel_q       <= sel_d;
            boot_q      <= boot_d;
            busy_q      <= busy_d;
        end
    end

    assign wb_s1   = sel_q[1];
    assign wb_s0   = sel_q[0];
    assign wb_boot = boot_q;
    assign busy    = busy_q;

endmodule
